// File: rtl/fifo_drain_pkg.sv
// fifo_package: shared FIFO word/counter widths and the word type
package fifo_package;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH = 16;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO read side (fifo_empty, fifo_data, fifo_rd_en) plus output stream (m_valid, m_ready, m_data) and drain_cnt; master = drain block, slave = environment
interface fifo_drain_if
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
  parameter int CNT_WIDTH = fifo_package::CNT_WIDTH
);
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic fifo_rd_en;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CNT_WIDTH-1:0] drain_cnt;
  modport master (
    input fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, drain_cnt
  );
  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input fifo_rd_en, m_valid, m_data, drain_cnt
  );
endinterface

// File: rtl/fifo_drain_buf.sv
// fifo_drain_buf: 2-entry circular buffer; clk/rst, wr_en/wr_data in, rd_ready in, valid/rd_data/pop/occ out
module fifo_drain_buf
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pop,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wr_ptr;
  logic rd_ptr;
  assign valid = occ != 2'd0;
  assign pop = valid & rd_ready;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, wr_en} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: FIFO read-side consumer; clk/rst plus fifo_drain_if.master (fifo_empty/fifo_data in, fifo_rd_en out, m_valid/m_data/drain_cnt out, m_ready in)
module fifo_drain
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
  parameter int CNT_WIDTH = fifo_package::CNT_WIDTH
) (
  input logic         clk,
  input logic         rst,
  fifo_drain_if.master bus
);
  logic inflight;
  logic pop;
  logic [1:0] occ;
  logic [2:0] credit;
  logic [CNT_WIDTH-1:0] cnt;
  // Slots committed after this edge; a read is safe only if at most one is committed.
  assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign bus.fifo_rd_en = !bus.fifo_empty && credit <= 3'd1;
  assign bus.drain_cnt = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      cnt <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (pop) cnt <= cnt + 1'b1;
    end
  end
  fifo_drain_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (bus.fifo_data),
    .rd_ready(bus.m_ready),
    .valid   (bus.m_valid),
    .rd_data (bus.m_data),
    .pop     (pop),
    .occ     (occ)
  );
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: randomized and directed bench for fifo_drain against a queue-based FIFO and scoreboard
module tb_fifo_drain;
  localparam int DW = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst;
  logic wr_req;
  logic [DW-1:0] wr_data;
  int checks = 0;
  int errors = 0;
  int reads = 0;
  int pops = 0;
  int run = 0;
  int last_run = 0;
  logic hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] fq [$];
  logic [DW-1:0] exp_q [$];
  fifo_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [DW-1:0] d);
    wr_req = 1'b1;
    wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask
  // FIFO model with registered empty and data_out; scoreboard holds every word written, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      exp_q.delete();
      bus.fifo_data <= '0;
      bus.fifo_empty <= 1'b1;
    end else begin
      if (bus.fifo_rd_en && !bus.fifo_empty) bus.fifo_data <= fq.pop_front();
      if (wr_req) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      bus.fifo_empty <= fq.size() == 0;
    end
  end
  // Every cycle: FIFO contract, output order, counter, hold stability and buffer bound.
  always @(negedge clk) begin
    if (rst) begin
      reads = 0;
      pops = 0;
      run = 0;
      last_run = 0;
      hold_pend = 1'b0;
    end else begin
      check("rd_when_empty", {31'b0, bus.fifo_rd_en & bus.fifo_empty}, 0);
      check("drain_cnt", {28'b0, bus.drain_cnt}, pops % 16);
      if (hold_pend) begin
        check("hold_valid", {31'b0, bus.m_valid}, 1);
        check("hold_data", {24'b0, bus.m_data}, {24'b0, hold_data});
      end
      hold_pend = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
      if (bus.m_valid) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (bus.fifo_rd_en) reads++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("extra_word", {24'b0, bus.m_data}, 32'hffff_ffff);
        else check("m_data_order", {24'b0, bus.m_data}, {24'b0, exp_q.pop_front()});
        pops++;
      end
      check("held_le_2", {31'b0, (reads - pops) <= 2}, 1);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int r0, p0;
    bit seen;
    rst = 1'b0;
    wr_req = 1'b0;
    wr_data = '0;
    bus.m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_rd_en", {31'b0, bus.fifo_rd_en}, 0);
    check("rst_m_valid", {31'b0, bus.m_valid}, 0);
    check("rst_m_data", {24'b0, bus.m_data}, 0);
    check("rst_drain_cnt", {28'b0, bus.drain_cnt}, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    push(8'hA5);
    @(negedge clk);
    check("single_rd_en", {31'b0, bus.fifo_rd_en}, 1);
    check("single_no_valid_yet", {31'b0, bus.m_valid}, 0);
    @(negedge clk);
    check("single_rd_once", {31'b0, bus.fifo_rd_en}, 0);
    check("single_latency", {31'b0, bus.m_valid}, 0);
    @(negedge clk);
    check("single_valid", {31'b0, bus.m_valid}, 1);
    check("single_data", {24'b0, bus.m_data}, 32'hA5);
    @(negedge clk);
    check("single_valid_drop", {31'b0, bus.m_valid}, 0);
    check("single_cnt", {28'b0, bus.drain_cnt}, 1);
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !bus.m_valid && last_run != 0;
    end
    check("stream_done", {31'b0, seen}, 1);
    check("stream_no_gaps", last_run, 8);
    check("stream_cnt", {28'b0, bus.drain_cnt}, 8);
    tick();
    bus.m_ready = 1'b0;
    r0 = reads;
    p0 = pops;
    for (int i = 0; i < 5; i++) push(DW'(8'h10 + i));
    repeat (10) tick();
    @(negedge clk);
    check("bp_reads", reads - r0, 2);
    check("bp_rd_low", {31'b0, bus.fifo_rd_en}, 0);
    check("bp_valid", {31'b0, bus.m_valid}, 1);
    check("bp_data", {24'b0, bus.m_data}, 32'h10);
    tick();
    bus.m_ready = 1'b1;
    repeat (12) tick();
    check("bp_delivered", pops - p0, 5);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_cnt", {28'b0, bus.drain_cnt}, 13);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(DW'(8'h31 + i));
    repeat (4) tick();
    @(negedge clk);
    check("mid_pre_valid", {31'b0, bus.m_valid}, 1);
    check("mid_pre_reads", reads - r0 - 5, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, bus.m_valid}, 0);
    check("mid_rst_cnt", {28'b0, bus.drain_cnt}, 0);
    check("mid_rst_data", {24'b0, bus.m_data}, 0);
    check("mid_rst_rd_en", {31'b0, bus.fifo_rd_en}, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(DW'($urandom));
    repeat (8) tick();
    @(negedge clk);
    check("wrap_cnt", {28'b0, bus.drain_cnt}, 1);
    check("wrap_pops", pops, 17);
    tick();
    for (int i = 0; i < 400; i++) begin
      wr_req = 1'($urandom_range(0, 1));
      wr_data = DW'($urandom);
      bus.m_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    wr_req = 1'b0;
    bus.m_ready = 1'b1;
    repeat (12) tick();
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_all_read", reads, pops);
    check("rand_idle_valid", {31'b0, bus.m_valid}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
